display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl.sv | 106 ++++++++++
 tb/tb_display_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Host-side bundle for the display scan controller: frame load, per-digit
// controls, and the signals driven toward the shared decoder and anodes.
interface display_scan_ctrl_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_en;
  logic [3:0]  dp_in;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        dp;
  logic        update_pending;

  modport master (
    output load, digits_in, blank_mask, blink_en, dp_in,
    input  num, an, dp, update_pending
  );

  modport slave (
    input  load, digits_in, blank_mask, blink_en, dp_in,
    output num, an, dp, update_pending
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: time-multiplexes one BCD decoder,
// blanks anodes around digit switches, and swaps frames only at scan end.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000,
  parameter int BLINK_DIV    = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  display_scan_ctrl_if.slave bus
);
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] SCAN_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {GUARD, DRIVE} state_t;

  logic [15:0]   shadow, active, shadow_nxt, active_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [BW-1:0] scan_cnt, scan_nxt;
  logic          blink_phase, phase_nxt;
  logic          pending, pend_nxt;
  logic [3:0]    num_q, an_q, num_nxt, an_nxt;
  logic          dp_q, dp_nxt;
  logic          in_guard, slot_end, bnd, lit;
  logic [3:0]    nib, dark;
  state_t        state;

  // GUARD is a pure decode of slot_cnt; a zero-length guard must never match.
  if (GUARD_CYCLES == 0) begin : g_noguard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [SW-1:0] GUARD_L = SW'(GUARD_CYCLES);
    assign in_guard = slot_cnt < GUARD_L;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dark
    assign dark[i] = bus.blank_mask[i] | (bus.blink_en[i] & blink_phase) |
                     (active[4*i +: 4] > 4'd9);
  end

  always_comb begin
    state      = in_guard ? GUARD : DRIVE;
    slot_end   = slot_cnt == SLOT_LAST;
    bnd        = slot_end && idx == 2'd3;
    slot_nxt   = slot_end ? '0 : slot_cnt + 1'b1;
    idx_nxt    = slot_end ? idx + 2'd1 : idx;
    scan_nxt   = scan_cnt;
    phase_nxt  = blink_phase;
    shadow_nxt = bus.load ? bus.digits_in : shadow;
    active_nxt = active;
    pend_nxt   = pending;
    if (bnd) begin
      if (scan_cnt == SCAN_LAST) begin
        scan_nxt  = '0;
        phase_nxt = ~blink_phase;
      end else begin
        scan_nxt  = scan_cnt + 1'b1;
      end
      // A load landing on the boundary edge bypasses the shadow wait.
      if (bus.load)     active_nxt = bus.digits_in;
      else if (pending) active_nxt = shadow;
      pend_nxt = 1'b0;
    end else if (bus.load) begin
      pend_nxt = 1'b1;
    end
    nib     = active[{idx, 2'b00} +: 4];
    lit     = !dark[idx] && state == DRIVE;
    num_nxt = (nib > 4'd9) ? 4'd0 : nib;
    an_nxt  = lit ? ~(4'b0001 << idx) : 4'b1111;
    dp_nxt  = lit ? ~bus.dp_in[idx] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      active      <= '0;
      idx         <= '0;
      slot_cnt    <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b0;
      num_q       <= '0;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      shadow      <= shadow_nxt;
      active      <= active_nxt;
      idx         <= idx_nxt;
      slot_cnt    <= slot_nxt;
      scan_cnt    <= scan_nxt;
      blink_phase <= phase_nxt;
      pending     <= pend_nxt;
      num_q       <= num_nxt;
      an_q        <= an_nxt;
      dp_q        <= dp_nxt;
    end
  end

  assign bus.num            = num_q;
  assign bus.an             = an_q;
  assign bus.dp             = dp_q;
  assign bus.update_pending = pending;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a cycle-count arithmetic model.
module tb_display_scan_ctrl;
  localparam int RD = 8, GC = 2, BD = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  display_scan_ctrl_if bus();

  display_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int c = 0;
  logic [15:0] m_active = '0, m_shadow = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: expected outputs come from the slot position implied by c.
  task automatic step(input logic ld, input logic [15:0] din);
    int pos, idx, bp;
    logic [3:0] nib, e_an, e_num;
    logic dark, e_dp, bnd;
    bus.load = ld;
    bus.digits_in = din;
    pos  = c % RD;
    idx  = (c / RD) % 4;
    bp   = (c / (4 * RD * BD)) % 2;
    nib  = m_active[idx*4 +: 4];
    dark = bus.blank_mask[idx] || (bus.blink_en[idx] && bp == 1) || nib > 9;
    if (dark || pos < GC) begin
      e_an = 4'b1111;
      e_dp = 1'b1;
    end else begin
      e_an = 4'b1111;
      e_an[idx] = 1'b0;
      e_dp = ~bus.dp_in[idx];
    end
    e_num = (nib > 9) ? 4'd0 : nib;
    bnd = (pos == RD - 1) && (idx == 3);
    @(posedge clk);
    if (ld) m_shadow = din;
    if (bnd) begin
      if (ld) m_active = din;
      else if (m_pend) m_active = m_shadow;
      m_pend = 1'b0;
    end else if (ld) m_pend = 1'b1;
    c++;
    #1;
    chk("an", bus.an, e_an);
    chk("dp", bus.dp, e_dp);
    chk("num", bus.num, e_num);
    chk("pending", bus.update_pending, m_pend);
    chk("an_onehot", ($countones(~bus.an) <= 1), 1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  // Advance until the next edge is at the given slot position/digit.
  task automatic run_to(input int pos, input int idx);
    for (int i = 0; i < 4 * RD && !((c % RD) == pos && ((c / RD) % 4) == idx); i++)
      step(1'b0, 16'h0);
  endtask

  initial begin
    bus.load = 0; bus.digits_in = 0; bus.blank_mask = 0; bus.blink_en = 0; bus.dp_in = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_an", bus.an, 4'b1111);
      chk("rst_dp", bus.dp, 1'b1);
      chk("rst_num", bus.num, 4'd0);
      chk("rst_pend", bus.update_pending, 1'b0);
    end
    rst_n = 1'b1;

    // Scan order, then a deferred double load during digit 1.
    step(1'b1, 16'h4321);
    run(4 * RD * 3);
    run_to(3, 1);
    step(1'b1, 16'h9876);
    step(1'b1, 16'h5555);
    run_to(0, 0);
    run(4 * RD);

    // Load on the boundary edge goes straight to the frame.
    run_to(RD - 1, 3);
    step(1'b1, 16'h0007);
    run(4 * RD);

    // Invalid digit 3, blanked digit 1, dp on digit 2.
    bus.blank_mask = 4'b0010; bus.dp_in = 4'b0100;
    run_to(RD - 1, 3);
    step(1'b1, 16'hA000);
    run(4 * RD * 2);

    // Blink digit 0 across several blink half-periods.
    bus.blank_mask = 0; bus.dp_in = 0; bus.blink_en = 4'b0001;
    run_to(RD - 1, 3);
    step(1'b1, 16'h1234);
    run(4 * RD * BD * 3);

    // Random controls and loads.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.blank_mask = 4'($urandom);
        bus.blink_en   = 4'($urandom);
        bus.dp_in      = 4'($urandom);
      end
      step($urandom_range(0, 19) == 0, 16'($urandom));
    end

    // Async reset mid-DRIVE with a load still pending.
    bus.blank_mask = 0; bus.blink_en = 0; bus.dp_in = 0;
    run_to(RD - 1, 3);
    step(1'b1, 16'h1234);
    run_to(4, 0);
    step(1'b1, 16'h9999);
    chk("pre_rst_pend", bus.update_pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", bus.an, 4'b1111);
    chk("async_dp", bus.dp, 1'b1);
    chk("async_num", bus.num, 4'd0);
    chk("async_pend", bus.update_pending, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0; m_active = '0; m_shadow = '0; m_pend = 1'b0;
    run(4 * RD * 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
